// File: rtl/gen_scheduler.sv
// Generation scheduler for an 8x8 cellular grid: loads a seed, paces generations
// from a programmable tick, supports pause/single-step and halts on extinction or stability.
module gen_scheduler #(
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              step,
    input  logic [RATE_W-1:0] rate,
    input  logic [63:0]       seed,
    input  logic [63:0]       grid_next,
    output logic [63:0]       grid,
    output logic              step_en,
    output logic [15:0]       gen_count,
    output logic [2:0]        state,
    output logic              stable,
    output logic              extinct
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [63:0]       grid_q, grid_d;
    logic [15:0]       gen_count_q, gen_count_d;
    logic [RATE_W-1:0] tick_q, tick_d;
    logic              stable_q, stable_d;
    logic              extinct_q, extinct_d;
    logic              apply_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Next-state, tick pacing and generation capture with halt detection
    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        gen_count_d = gen_count_q;
        tick_d      = tick_q;
        stable_d    = stable_q;
        extinct_d   = extinct_q;
        apply_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                grid_d      = seed;
                gen_count_d = 16'd0;
                tick_d      = '0;
                stable_d    = 1'b0;
                extinct_d   = 1'b0;
                if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (tick_q == rate) begin
                    tick_d  = '0;
                    apply_s = 1'b1;
                end else begin
                    // Free-running wrap lets a lowered rate catch up through the maximum
                    tick_d = tick_q + {{(RATE_W-1){1'b0}}, 1'b1};
                end
            end
            ST_PAUSE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    apply_s = step;
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The halting generation itself is still captured; extinction outranks stability
        if (apply_s) begin
            grid_d      = grid_next;
            gen_count_d = sat_inc(gen_count_q);
            if (grid_next == 64'd0) begin
                extinct_d = 1'b1;
                state_d   = ST_HALT;
            end else if (grid_next == grid_q) begin
                stable_d = 1'b1;
                state_d  = ST_HALT;
            end else begin
                state_d = state_d;
            end
        end else begin
            grid_d = grid_d;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grid_q      <= 64'd0;
            gen_count_q <= 16'd0;
            tick_q      <= '0;
            stable_q    <= 1'b0;
            extinct_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            gen_count_q <= gen_count_d;
            tick_q      <= tick_d;
            stable_q    <= stable_d;
            extinct_q   <= extinct_d;
        end
    end

    assign grid      = grid_q;
    assign step_en   = apply_s;
    assign gen_count = gen_count_q;
    assign state     = state_q;
    assign stable    = stable_q;
    assign extinct   = extinct_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Self-checking bench for gen_scheduler: directed vector table, multi-cycle corner
// sequences and randomized traffic against a behavioural reference model.
module tb_gen_scheduler;

    logic        clk = 1'b0;
    logic        reset, start, pause, step;
    logic [3:0]  rate;
    logic [63:0] seed, grid_next, grid;
    logic        step_en, stable, extinct;
    logic [15:0] gen_count;
    logic [2:0]  state;

    int          nx_mode;
    logic [63:0] nx_mask;
    int          checks = 0;
    int          errors = 0;

    localparam logic [63:0] SA = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] SB = 64'h0000_0000_0000_00FF;

    gen_scheduler #(.RATE_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step),
        .rate(rate), .seed(seed), .grid_next(grid_next), .grid(grid),
        .step_en(step_en), .gen_count(gen_count), .state(state),
        .stable(stable), .extinct(extinct)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        int k;
        k = n % 64;
        if (k == 0) return x;
        return (x << k) | (x >> (64 - k));
    endfunction

    // Stand-in for the combinational life datapath
    function automatic logic [63:0] nxt(input logic [63:0] g, input int m, input logic [63:0] mk);
        case (m)
            0:       return rotl(g, 1);
            1:       return g;
            2:       return 64'd0;
            default: return g ^ mk;
        endcase
    endfunction

    assign grid_next = nxt(grid, nx_mode, nx_mask);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] e_st, input logic e_se,
                           input logic [15:0] e_gen, input logic [63:0] e_grid, input logic [1:0] e_fl);
        chk({tag, "_state"},   64'(state),     64'(e_st));
        chk({tag, "_step_en"}, 64'(step_en),   64'(e_se));
        chk({tag, "_gen"},     64'(gen_count), 64'(e_gen));
        chk({tag, "_grid"},    grid,           e_grid);
        chk({tag, "_flags"},   64'({stable, extinct}), 64'(e_fl));
    endtask

    typedef struct {
        logic        start, pause, step;
        logic [63:0] seed;
        int          mode;
        logic [2:0]  e_state;
        logic        e_step;
        logic [15:0] e_gen;
        logic [63:0] e_grid;
        logic [1:0]  e_flags;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic p, input logic st, input logic [63:0] sd,
                                input int md, input logic [2:0] es, input logic ese,
                                input logic [15:0] eg, input logic [63:0] egr, input logic [1:0] ef);
        vec_t v;
        v.start = s; v.pause = p; v.step = st; v.seed = sd; v.mode = md;
        v.e_state = es; v.e_step = ese; v.e_gen = eg; v.e_grid = egr; v.e_flags = ef;
        return v;
    endfunction

    vec_t tbl[20];

    // Reference model state
    int          m_st, n_st, m_gen, m_tick;
    logic [63:0] m_grid, gn;
    logic        m_stab, m_ext, go;

    initial begin
        int idx[$];
        int steps;
        bit ok;

        tbl[0]  = mk(1'b1, 1'b0, 1'b0, SA, 0, 3'd0, 1'b0, 16'd0, 64'd0,        2'b00);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, SA, 0, 3'd1, 1'b0, 16'd0, 64'd0,        2'b00);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, SA, 0, 3'd2, 1'b1, 16'd0, SA,           2'b00);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, SA, 0, 3'd2, 1'b1, 16'd1, rotl(SA, 1),  2'b00);
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, SA, 0, 3'd2, 1'b1, 16'd2, rotl(SA, 2),  2'b00);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, SA, 0, 3'd2, 1'b0, 16'd3, rotl(SA, 3),  2'b00);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, SA, 0, 3'd3, 1'b0, 16'd3, rotl(SA, 3),  2'b00);
        tbl[7]  = mk(1'b0, 1'b1, 1'b1, SA, 0, 3'd3, 1'b1, 16'd3, rotl(SA, 3),  2'b00);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, SA, 0, 3'd3, 1'b0, 16'd4, rotl(SA, 4),  2'b00);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, SA, 0, 3'd3, 1'b0, 16'd4, rotl(SA, 4),  2'b00);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, SA, 0, 3'd2, 1'b1, 16'd4, rotl(SA, 4),  2'b00);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, SB, 1, 3'd2, 1'b0, 16'd5, rotl(SA, 5),  2'b00);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, SB, 1, 3'd1, 1'b0, 16'd5, rotl(SA, 5),  2'b00);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, SB, 1, 3'd2, 1'b1, 16'd0, SB,           2'b00);
        tbl[14] = mk(1'b0, 1'b0, 1'b1, SB, 1, 3'd4, 1'b0, 16'd1, SB,           2'b10);
        tbl[15] = mk(1'b0, 1'b1, 1'b1, SB, 1, 3'd4, 1'b0, 16'd1, SB,           2'b10);
        tbl[16] = mk(1'b1, 1'b0, 1'b0, 64'd0, 2, 3'd4, 1'b0, 16'd1, SB,        2'b10);
        tbl[17] = mk(1'b0, 1'b0, 1'b0, 64'd0, 2, 3'd1, 1'b0, 16'd1, SB,        2'b10);
        tbl[18] = mk(1'b0, 1'b0, 1'b0, 64'd0, 2, 3'd2, 1'b1, 16'd0, 64'd0,     2'b00);
        tbl[19] = mk(1'b0, 1'b0, 1'b0, 64'd0, 2, 3'd4, 1'b0, 16'd1, 64'd0,     2'b01);

        reset = 1'b1; start = 1'b0; pause = 1'b0; step = 1'b0; rate = 4'd0;
        seed = 64'd0; nx_mode = 0; nx_mask = 64'd0;
        #1;
        chk_all("reset", 3'd0, 1'b0, 16'd0, 64'd0, 2'b00);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            start = tbl[i].start; pause = tbl[i].pause; step = tbl[i].step;
            seed = tbl[i].seed; nx_mode = tbl[i].mode;
            #4;
            chk_all($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_step,
                    tbl[i].e_gen, tbl[i].e_grid, tbl[i].e_flags);
            @(posedge clk); #1;
        end

        // rate=3: 5 pulses in 20 RUN cycles, 4 apart
        step = 1'b0; pause = 1'b0; seed = SA; nx_mode = 0; rate = 4'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            #4;
            if (step_en) idx.push_back(c);
            @(posedge clk); #1;
        end
        chk("rate3_pulses", 64'(idx.size()), 64'd5);
        ok = (idx.size() == 5) && (idx[0] == 3);
        for (int k = 1; k < idx.size(); k++) if (idx[k] - idx[k-1] != 4) ok = 1'b0;
        chk("rate3_spacing", 64'(ok), 64'd1);
        chk("rate3_gen", 64'(gen_count), 64'd5);

        // Lowering rate below the current count wraps through the maximum
        rate = 4'd15;
        idx.delete();
        for (int c = 0; c < 11; c++) begin
            #4; if (step_en) idx.push_back(c);
            @(posedge clk); #1;
        end
        chk("rate15_quiet", 64'(idx.size()), 64'd0);
        rate = 4'd3;
        for (int c = 0; c < 12; c++) begin
            #4; if (step_en) idx.push_back(c);
            @(posedge clk); #1;
        end
        chk("ratechg_first", (idx.size() > 0) ? 64'(idx[0]) : 64'hDEAD, 64'd8);

        // gen_count saturation while the grid keeps advancing
        rate = 4'd0; seed = SA; nx_mode = 0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        steps = 0;
        for (int c = 0; c < 65537; c++) begin
            #4; if (step_en) steps++;
            @(posedge clk); #1;
        end
        #4;
        chk("sat_steps", 64'(steps), 64'd65537);
        chk("sat_gen", 64'(gen_count), 64'hFFFF);
        chk("sat_grid", grid, rotl(SA, 65537));
        chk("sat_step_en", 64'(step_en), 64'd1);

        // Asynchronous reset between edges, start held across release
        @(posedge clk); #3;
        reset = 1'b1; start = 1'b1;
        #1;
        chk_all("async_rst", 3'd0, 1'b0, 16'd0, 64'd0, 2'b00);
        @(posedge clk); #1;
        chk("rst_hold_state", 64'(state), 64'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_load", 64'(state), 64'd1);
        start = 1'b0;

        // Randomized traffic against the reference model (currently in LOAD)
        m_st = 1; m_grid = 64'd0; m_gen = 0; m_tick = 0; m_stab = 1'b0; m_ext = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            start = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 8) pause = ~pause;
            step = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 99) < 4) rate = 4'($urandom_range(0, 15));
            seed = ($urandom_range(0, 19) == 0) ? 64'd0 : {$urandom, $urandom};
            r = $urandom_range(0, 99);
            nx_mode = (r < 85) ? 0 : (r < 90) ? 1 : (r < 94) ? 2 : 3;
            nx_mask = {$urandom, $urandom} | 64'd1;
            gn = nxt(m_grid, nx_mode, nx_mask);

            go = 1'b0; n_st = m_st;
            if (m_st == 0) begin
                if (start) n_st = 1;
            end else if (m_st == 1) begin
                n_st = pause ? 3 : 2;
            end else if (start) begin
                n_st = 1;
            end else if (m_st == 2) begin
                if (pause) n_st = 3;
                else if (m_tick == int'(rate)) go = 1'b1;
            end else if (m_st == 3) begin
                go = step;
                n_st = pause ? 3 : 2;
            end

            #4;
            chk_all($sformatf("rnd%0d", c), 3'(m_st), go, 16'(m_gen), m_grid, {m_stab, m_ext});

            if (m_st == 1) begin
                m_grid = seed; m_gen = 0; m_tick = 0; m_stab = 1'b0; m_ext = 1'b0;
            end
            if (m_st == 2 && !start && !pause) m_tick = go ? 0 : (m_tick + 1) % 16;
            if (go) begin
                if (gn == 64'd0) begin
                    m_ext = 1'b1; n_st = 4;
                end else if (gn == m_grid) begin
                    m_stab = 1'b1; n_st = 4;
                end
                m_grid = gn;
                m_gen = (m_gen < 65535) ? m_gen + 1 : 65535;
            end
            m_st = n_st;
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
